// File: rtl/e203_exu_flush_arb.sv
// Flush arbiter: merges debug, exception and branch flush requests onto the single IFU flush port.
// Optional PC forwarding path is enabled with `define E203_FLUSH_ARB_PC_EN.
module e203_exu_flush_arb #(
  parameter int unsigned PC_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,

  input  logic            dbg_flush_req,
  input  logic [PC_W-1:0] dbg_flush_add_op1,
  input  logic [PC_W-1:0] dbg_flush_add_op2,
  output logic            dbg_flush_ack,

  input  logic            excp_flush_req,
  input  logic [PC_W-1:0] excp_flush_add_op1,
  input  logic [PC_W-1:0] excp_flush_add_op2,
  output logic            excp_flush_ack,

  input  logic            brch_flush_req,
  input  logic [PC_W-1:0] brch_flush_add_op1,
  input  logic [PC_W-1:0] brch_flush_add_op2,
  output logic            brch_flush_ack,

  output logic            pipe_flush_req,
  input  logic            pipe_flush_ack,
  output logic [PC_W-1:0] pipe_flush_add_op1,
  output logic [PC_W-1:0] pipe_flush_add_op2,

`ifdef E203_FLUSH_ARB_PC_EN
  input  logic [PC_W-1:0] dbg_flush_pc,
  input  logic [PC_W-1:0] excp_flush_pc,
  input  logic [PC_W-1:0] brch_flush_pc,
  output logic [PC_W-1:0] pipe_flush_pc,
`endif

  output logic            flush_pulse,
  output logic            arb_busy,
  output logic [7:0]      flush_cnt
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  localparam logic [1:0] ID_NONE = 2'd0;
  localparam logic [1:0] ID_DBG  = 2'd1;
  localparam logic [1:0] ID_EXCP = 2'd2;
  localparam logic [1:0] ID_BRCH = 2'd3;

  logic [0:0]      state_q, state_d;
  logic [1:0]      id_q, id_d;
  logic [PC_W-1:0] op1_q, op1_d;
  logic [PC_W-1:0] op2_q, op2_d;
  logic [7:0]      cnt_q, cnt_d;

  logic [1:0]      win_id;
  logic [PC_W-1:0] win_op1;
  logic [PC_W-1:0] win_op2;
  logic [1:0]      gnt_id;
  logic            held_req;

`ifdef E203_FLUSH_ARB_PC_EN
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] win_pc;
`endif

  // Fixed-priority pick among live requests: dbg > excp > brch.
  always_comb begin
    win_id  = ID_NONE;
    win_op1 = '0;
    win_op2 = '0;
`ifdef E203_FLUSH_ARB_PC_EN
    win_pc  = '0;
`endif
    if (dbg_flush_req) begin
      win_id  = ID_DBG;
      win_op1 = dbg_flush_add_op1;
      win_op2 = dbg_flush_add_op2;
`ifdef E203_FLUSH_ARB_PC_EN
      win_pc  = dbg_flush_pc;
`endif
    end else if (excp_flush_req) begin
      win_id  = ID_EXCP;
      win_op1 = excp_flush_add_op1;
      win_op2 = excp_flush_add_op2;
`ifdef E203_FLUSH_ARB_PC_EN
      win_pc  = excp_flush_pc;
`endif
    end else if (brch_flush_req) begin
      win_id  = ID_BRCH;
      win_op1 = brch_flush_add_op1;
      win_op2 = brch_flush_add_op2;
`ifdef E203_FLUSH_ARB_PC_EN
      win_pc  = brch_flush_pc;
`endif
    end
  end

  // Whether the requester owning the held grant is still asking.
  always_comb begin
    case (id_q)
      ID_DBG:  held_req = dbg_flush_req;
      ID_EXCP: held_req = excp_flush_req;
      ID_BRCH: held_req = brch_flush_req;
      default: held_req = 1'b0;
    endcase
  end

  // Next-state and IFU-side outputs; HOLD replays the latched grant and ignores newcomers.
  always_comb begin
    state_d            = state_q;
    id_d               = id_q;
    op1_d              = op1_q;
    op2_d              = op2_q;
`ifdef E203_FLUSH_ARB_PC_EN
    pc_d               = pc_q;
    pipe_flush_pc      = '0;
`endif
    gnt_id             = ID_NONE;
    pipe_flush_req     = 1'b0;
    pipe_flush_add_op1 = '0;
    pipe_flush_add_op2 = '0;

    case (state_q)
      ST_IDLE: begin
        if (win_id != ID_NONE) begin
          gnt_id             = win_id;
          pipe_flush_req     = 1'b1;
          pipe_flush_add_op1 = win_op1;
          pipe_flush_add_op2 = win_op2;
`ifdef E203_FLUSH_ARB_PC_EN
          pipe_flush_pc      = win_pc;
`endif
          if (!pipe_flush_ack) begin
            state_d = ST_HOLD;
            id_d    = win_id;
            op1_d   = win_op1;
            op2_d   = win_op2;
`ifdef E203_FLUSH_ARB_PC_EN
            pc_d    = win_pc;
`endif
          end
        end
      end
      ST_HOLD: begin
        gnt_id             = id_q;
        pipe_flush_req     = 1'b1;
        pipe_flush_add_op1 = op1_q;
        pipe_flush_add_op2 = op2_q;
`ifdef E203_FLUSH_ARB_PC_EN
        pipe_flush_pc      = pc_q;
`endif
        // Completion or abandonment by the requester both release the port.
        if (pipe_flush_ack || !held_req) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign flush_pulse    = pipe_flush_req & pipe_flush_ack;
  assign dbg_flush_ack  = flush_pulse & (gnt_id == ID_DBG);
  assign excp_flush_ack = flush_pulse & (gnt_id == ID_EXCP);
  assign brch_flush_ack = flush_pulse & (gnt_id == ID_BRCH);

  assign cnt_d     = flush_pulse ? cnt_q + 8'd1 : cnt_q;
  assign arb_busy  = (state_q == ST_HOLD);
  assign flush_cnt = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      id_q    <= ID_NONE;
      op1_q   <= '0;
      op2_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef E203_FLUSH_ARB_PC_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end
`endif

endmodule
